reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning register count (power of two, 2 to 64).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning register width in bits.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning read-port count (1 to 4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to zero.
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 forwards same-cycle write data to reads.
REQ-006 SHALL have derived parameter ADR_WIDTH = $clog2(NUM_REGS).
REQ-007 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port rd_addr_i  input  NUM_RD*ADR_WIDTH  read addresses, port k at bits [k*ADR_WIDTH +: ADR_WIDTH].
REQ-010 SHALL have port rd_data_o  output  NUM_RD*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port rd_busy_o  output  NUM_RD  pending flag of each read port's addressed register.
REQ-012 SHALL have port wen_i  input  1  write enable.
REQ-013 SHALL have port wa_i  input  ADR_WIDTH  write address.
REQ-014 SHALL have port write_data_i  input  DATA_WIDTH  write data.
REQ-015 SHALL have port claim_i  input  1  request to mark a register pending (producer in flight).
REQ-016 SHALL have port claim_addr_i  input  ADR_WIDTH  register to claim.
REQ-017 SHALL have port claim_ok_o  output  1  combinational grant of the current claim.
REQ-018 SHALL have port busy_cnt_o  output  ADR_WIDTH+1  registered count of pending registers.

Function
REQ-019 SHALL store NUM_REGS x DATA_WIDTH data and one busy bit per register.
REQ-020 SHALL make reads combinational: rd_data_o[k] = RF[rd_addr_i[k]], zero latency.
REQ-021 SHALL make writes synchronous: on a rising edge with wen_i=1, RF[wa_i] <= write_data_i; readable on the following cycle.
REQ-022 SHALL, when BYPASS=1 and wen_i=1 and wa_i equals rd_addr_i[k], drive write_data_i on port k and drive rd_busy_o[k]=0 in that same cycle.
REQ-023 SHALL, when ZERO_REG=1, return zero and rd_busy_o=0 for address 0, ignore writes to 0 and deny claims of 0; bypass never applies to address 0.
REQ-024 SHALL drive rd_busy_o[k] = busy[rd_addr_i[k]] except as stated in REQ-022/023.
REQ-025 SHALL assert claim_ok_o = claim_i and (busy[claim_addr_i]=0, or wen_i=1 with wa_i=claim_addr_i) and not (ZERO_REG=1 and claim_addr_i=0).
REQ-026 SHALL set busy[claim_addr_i] on a rising edge where claim_ok_o=1; a denied claim changes no state.
REQ-027 SHALL clear busy[wa_i] on a rising edge where wen_i=1.
REQ-028 SHALL, on a simultaneous granted claim and write to the same register, commit the data and leave busy=1 (claim wins).
REQ-029 SHALL accept writes to a non-busy register and leave its busy bit at 0.
REQ-030 SHALL update busy_cnt_o each edge by +1 per newly set bit and -1 per newly cleared bit, always equal to the population count of busy bits after the edge, range 0..NUM_REGS with no wrap.
REQ-031 SHALL treat out-of-range or X addresses as don't-care; no extra checks required.

Reset
REQ-032 SHALL, while reset=1, immediately and independently of clk clear all registers to 0, all busy bits to 0 and busy_cnt_o to 0.
REQ-033 SHALL ignore wen_i and claim_i while reset=1; an operation in the edge coinciding with reset assertion is discarded.
REQ-034 SHALL resume normal operation on the first rising edge after reset deasserts, with rd_data_o=0 and rd_busy_o=0 for every address until written or claimed.

Verification
REQ-035 SHALL cover: reset mid-run with R3=0x1234 busy -> R3 reads 0x0000, rd_busy_o=0, busy_cnt_o=0 before the next edge.
REQ-036 SHALL cover: write R5=0xBEEF, same cycle read port 1 at 5 -> BYPASS=1 gives 0xBEEF that cycle; BYPASS=0 gives old value, then 0xBEEF next cycle.
REQ-037 SHALL cover: claim R2 -> claim_ok_o=1, busy_cnt_o=1; claim R2 again -> claim_ok_o=0, count stays 1; write R2=0x0042 -> busy clear, count 0.
REQ-038 SHALL cover: R4 busy, same cycle write R4=0x00AA and claim R4 -> claim_ok_o=1, R4=0x00AA, busy stays 1, count unchanged.
REQ-039 SHALL cover: ZERO_REG=1, write R0=0xFFFF and claim R0 -> R0 reads 0, claim_ok_o=0, count unchanged.
REQ-040 SHALL cover: claim all NUM_REGS-ZERO_REG registers in sequence -> busy_cnt_o reaches 7 (defaults) without wrap, further claims denied.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register scoreboard (busy) bits.
//
// Each register holds DATA_WIDTH bits of data and one busy bit. A producer
// claims a register (sets busy) when it starts, and the write of its result
// clears busy. Reads are combinational and report the busy bit of the
// addressed register so consumers can stall on pending values.
//
// Ports:
//   clk           - single clock, all state updates on its rising edge
//   reset         - asynchronous, active-high; clears data, busy bits, count
//   rd_addr_i     - NUM_RD packed read addresses, port k at [k*ADR_WIDTH +: ADR_WIDTH]
//   rd_data_o     - NUM_RD packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy_o     - busy flag of each read port's addressed register
//   wen_i         - write enable
//   wa_i          - write address
//   write_data_i  - write data
//   claim_i       - request to mark claim_addr_i pending
//   claim_addr_i  - register to claim
//   claim_ok_o    - combinational grant of the current claim
//   busy_cnt_o    - registered count of busy registers
module reg_file_sb #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int ADR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD*ADR_WIDTH-1:0]  rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic                         wen_i,
    input  logic [ADR_WIDTH-1:0]         wa_i,
    input  logic [DATA_WIDTH-1:0]        write_data_i,
    input  logic                         claim_i,
    input  logic [ADR_WIDTH-1:0]         claim_addr_i,
    output logic                         claim_ok_o,
    output logic [ADR_WIDTH:0]           busy_cnt_o
);

    logic [DATA_WIDTH-1:0] rf [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic [ADR_WIDTH:0]    cnt_nxt;
    logic                  wr_en;
    logic                  set_new;
    logic                  clr_new;
    logic                  wa_is_zero;
    logic                  ca_is_zero;

    assign wa_is_zero = (ZERO_REG != 0) && (wa_i == '0);
    assign ca_is_zero = (ZERO_REG != 0) && (claim_addr_i == '0);

    // Writes to a hardwired zero register are dropped so rf[0] stays 0.
    assign wr_en = wen_i && !wa_is_zero;

    // A busy register may be re-claimed in the same cycle its producer writes
    // back, since the write frees it at this very edge.
    assign claim_ok_o = claim_i && !ca_is_zero &&
                        (!busy[claim_addr_i] || (wen_i && (wa_i == claim_addr_i)));

    // Clear from write first, then set from claim, so a same-register
    // write+claim leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wen_i) begin
            busy_nxt[wa_i] = 1'b0;
        end
        if (claim_ok_o) begin
            busy_nxt[claim_addr_i] = 1'b1;
        end
    end

    // Count tracks transitions only: a set bit re-claimed by its own
    // write-back neither rises nor falls.
    assign set_new = claim_ok_o && !busy[claim_addr_i];
    assign clr_new = wen_i && busy[wa_i] && !(claim_ok_o && (claim_addr_i == wa_i));
    assign cnt_nxt = busy_cnt_o + (ADR_WIDTH+1)'(set_new) - (ADR_WIDTH+1)'(clr_new);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
            busy       <= '0;
            busy_cnt_o <= '0;
        end else begin
            if (wr_en) begin
                rf[wa_i] <= write_data_i;
            end
            busy       <= busy_nxt;
            busy_cnt_o <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADR_WIDTH-1:0] addr;
        logic                 is_zero;
        logic                 is_byp;

        assign addr    = rd_addr_i[k*ADR_WIDTH +: ADR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign is_byp  = (BYPASS != 0) && wen_i && (wa_i == addr) && !is_zero;

        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
            is_zero ? '0 : (is_byp ? write_data_i : rf[addr]);
        // Forwarded data is the completed result, so it is never pending.
        assign rd_busy_o[k] = !is_zero && !is_byp && busy[addr];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Two instances share all
// inputs: u_byp (BYPASS=1) and u_nob (BYPASS=0), both with ZERO_REG=1 and
// default sizes (8 x 16 bit, 2 read ports).
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic        wen = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;
    logic        claim = 1'b0;
    logic [2:0]  ca = '0;

    logic [31:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        claim_ok_b, claim_ok_n;
    logic [3:0]  cnt_b, cnt_n;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_busy_o(rd_busy_b), .wen_i(wen), .wa_i(wa), .write_data_i(wd),
        .claim_i(claim), .claim_addr_i(ca), .claim_ok_o(claim_ok_b),
        .busy_cnt_o(cnt_b)
    );

    reg_file_sb #(.BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
        .rd_busy_o(rd_busy_n), .wen_i(wen), .wa_i(wa), .write_data_i(wd),
        .claim_i(claim), .claim_addr_i(ca), .claim_ok_o(claim_ok_n),
        .busy_cnt_o(cnt_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs just after the falling edge, then settle.
    task automatic drive(input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic c, input logic [2:0] cadr,
                         input logic [2:0] r0, input logic [2:0] r1);
        @(negedge clk);
        wen = w; wa = a; wd = d; claim = c; ca = cadr;
        rd_addr = {r1, r0};
        #1;
    endtask

    task automatic idle(input logic [2:0] r0, input logic [2:0] r1);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, r0, r1);
    endtask

    // Let the rising edge commit the current inputs, then sample.
    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Async reset with no clock edge yet.
        #1 reset = 1'b1;
        #1;
        chk("rst_cnt", 32'(cnt_b), 32'd0);
        chk("rst_rd0", 32'(rd_data_b[15:0]), 32'h0);
        chk("rst_busy", 32'(rd_busy_b), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Post-reset: an arbitrary register reads zero and not busy.
        idle(3'd6, 3'd1);
        chk("post_rst_r6", 32'(rd_data_b[15:0]), 32'h0);
        chk("post_rst_r1", 32'(rd_data_b[31:16]), 32'h0);
        chk("post_rst_busy", 32'(rd_busy_b), 32'h0);

        // Write R5=BEEF while port 1 reads 5.
        drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd5);
        chk("byp_same_cyc", 32'(rd_data_b[31:16]), 32'hBEEF);
        chk("nob_same_cyc", 32'(rd_data_n[31:16]), 32'h0000);
        edge_then_sample();
        wen = 1'b0; #1;
        chk("byp_next_cyc", 32'(rd_data_b[31:16]), 32'hBEEF);
        chk("nob_next_cyc", 32'(rd_data_n[31:16]), 32'hBEEF);
        chk("r5_not_busy", 32'(rd_busy_b), 32'h0);
        chk("cnt_after_plain_wr", 32'(cnt_b), 32'd0);

        // Claim R2, re-claim denied, then write-back frees it.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 3'd0);
        chk("claim_r2_ok", 32'(claim_ok_b), 32'd1);
        edge_then_sample();
        chk("claim_r2_cnt", 32'(cnt_b), 32'd1);
        chk("claim_r2_busy", 32'(rd_busy_b), 32'b01);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 3'd0);
        chk("reclaim_r2_denied", 32'(claim_ok_b), 32'd0);
        edge_then_sample();
        chk("reclaim_r2_cnt", 32'(cnt_b), 32'd1);
        drive(1'b1, 3'd2, 16'h0042, 1'b0, 3'd0, 3'd2, 3'd0);
        chk("wr_r2_byp_data", 32'(rd_data_b[15:0]), 32'h0042);
        chk("wr_r2_byp_busy", 32'(rd_busy_b), 32'b00);
        chk("wr_r2_nob_busy", 32'(rd_busy_n), 32'b01);
        edge_then_sample();
        wen = 1'b0; #1;
        chk("wr_r2_cnt", 32'(cnt_n), 32'd0);
        chk("wr_r2_data", 32'(rd_data_n[15:0]), 32'h0042);
        chk("wr_r2_busy_clr", 32'(rd_busy_n), 32'b00);

        // R4 busy; same-cycle write-back and claim: claim wins.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd4, 3'd0);
        edge_then_sample();
        chk("claim_r4_cnt", 32'(cnt_b), 32'd1);
        drive(1'b1, 3'd4, 16'h00AA, 1'b1, 3'd4, 3'd4, 3'd0);
        chk("wr_claim_r4_ok", 32'(claim_ok_b), 32'd1);
        edge_then_sample();
        idle(3'd4, 3'd0);
        chk("wr_claim_r4_data", 32'(rd_data_b[15:0]), 32'h00AA);
        chk("wr_claim_r4_busy", 32'(rd_busy_b), 32'b01);
        chk("wr_claim_r4_cnt", 32'(cnt_b), 32'd1);
        drive(1'b1, 3'd4, 16'h00AB, 1'b0, 3'd0, 3'd4, 3'd0);
        edge_then_sample();
        chk("free_r4_cnt", 32'(cnt_b), 32'd0);

        // Register 0: write and claim ignored.
        drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        chk("r0_claim_denied", 32'(claim_ok_b), 32'd0);
        chk("r0_no_bypass", 32'(rd_data_b[15:0]), 32'h0);
        edge_then_sample();
        idle(3'd0, 3'd0);
        chk("r0_reads_zero", 32'(rd_data_b), 32'h0);
        chk("r0_not_busy", 32'(rd_busy_b), 32'b00);
        chk("r0_cnt", 32'(cnt_b), 32'd0);

        // Claim R1..R7 in turn; count climbs to 7, then everything is denied.
        for (int r = 1; r < 8; r++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(r), 3'd0, 3'd0);
            chk($sformatf("fill_ok_r%0d", r), 32'(claim_ok_b), 32'd1);
            edge_then_sample();
            chk($sformatf("fill_cnt_r%0d", r), 32'(cnt_b), 32'(r));
        end
        for (int r = 0; r < 8; r++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(r), 3'd0, 3'd0);
            chk($sformatf("full_deny_r%0d", r), 32'(claim_ok_b), 32'd0);
            edge_then_sample();
            chk($sformatf("full_cnt_r%0d", r), 32'(cnt_n), 32'd7);
        end

        // R3=1234 and still busy, then reset mid-cycle.
        drive(1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 3'd0, 3'd3);
        edge_then_sample();
        idle(3'd0, 3'd3);
        chk("pre_rst_r3", 32'(rd_data_b[31:16]), 32'h1234);
        chk("pre_rst_busy", 32'(rd_busy_b), 32'b10);
        chk("pre_rst_cnt", 32'(cnt_b), 32'd7);
        reset = 1'b1;
        #1;
        chk("mid_rst_r3", 32'(rd_data_b[31:16]), 32'h0);
        chk("mid_rst_busy", 32'(rd_busy_b), 32'b00);
        chk("mid_rst_cnt", 32'(cnt_b), 32'd0);
        // Operations during reset are discarded.
        wen = 1'b1; wa = 3'd3; wd = 16'h5555; claim = 1'b1; ca = 3'd3;
        edge_then_sample();
        wen = 1'b0; claim = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(3'd0, 3'd3);
        chk("after_rst_r3", 32'(rd_data_b[31:16]), 32'h0);
        chk("after_rst_busy", 32'(rd_busy_b), 32'b00);
        chk("after_rst_cnt", 32'(cnt_b), 32'd0);

        // Normal operation resumes.
        drive(1'b1, 3'd7, 16'h7777, 1'b1, 3'd6, 3'd7, 3'd6);
        edge_then_sample();
        idle(3'd7, 3'd6);
        chk("resume_r7", 32'(rd_data_n[15:0]), 32'h7777);
        chk("resume_busy", 32'(rd_busy_n), 32'b10);
        chk("resume_cnt", 32'(cnt_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
